// File: rtl/stream_pkg.sv
// Shared types and defaults for the sampled-flow buffer.
package stream_pkg;

   localparam int DATA_MSB   = 7;
   localparam int FIFO_DEPTH = 4;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);

   typedef logic [DATA_MSB:0] flow_t;

endpackage

// File: rtl/stream_sample_buffer_if.sv
// Valid/ready stream carrying the FIFO head to the consumer.
// A word transfers on a rising clk edge where valid & ready are both 1; data is stable while valid & ~ready.
interface stream_sample_buffer_if #(
   parameter int N = 7
) ();

   logic       valid;
   logic       ready;
   logic [N:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/stream_sample_buffer_fifo.sv
// Storage, wrapping pointers and occupancy count for the sample FIFO.
module sync_fifo_core
   import stream_pkg::*;
#(
   parameter int N     = DATA_MSB,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic        flush,
   input  logic [N:0]  wr_data,
   output logic [N:0]  rd_data,
   output logic [AW:0] level,
   output logic        full,
   output logic        empty
);

   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [N:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   level_q;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level_q == '0);
   assign full    = (level_q == FULL_LVL);
   assign level   = level_q;
   assign rd_data = mem[rd_ptr];

   // When full, a write is only legal because the head is leaving on the same edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LVL_ONE;
            2'b01:   level_q <= level_q - LVL_ONE;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/stream_sample_buffer.sv
// `val when sample` into a small FIFO drained by valid/ready, plus `current(val when sample)` held output.
module stream_sample_buffer
   import stream_pkg::*;
#(
   parameter int N     = DATA_MSB,
   parameter int DEPTH = FIFO_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      init,
   input  logic [N:0]                val,
   input  logic                      sample,
   stream_sample_buffer_if.master    out,
   output logic [N:0]                cur_val,
   output logic                      cur_valid,
   output logic [AW:0]               level,
   output logic                      overflow
);

   logic       push;
   logic       pop;
   logic       full;
   logic       empty;
   logic [N:0] head;
   logic [N:0] cur_val_q;
   logic       cur_valid_q;
   logic       overflow_q;

   // init discards any handshake or sample landing in the same cycle.
   assign pop  = ~empty & out.ready & ~init;
   assign push = sample & ~init & (~full | pop);

   sync_fifo_core #(
      .N     (N),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (init),
      .wr_data (val),
      .rd_data (head),
      .level   (level),
      .full    (full),
      .empty   (empty)
   );

   assign out.valid = ~empty;
   assign out.data  = empty ? '0 : head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (init) begin
         overflow_q <= 1'b0;
      end else if (sample && full && !pop) begin
         overflow_q <= 1'b1;
      end
   end

   // The held value follows every sample, including ones the FIFO had to drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_val_q   <= '0;
         cur_valid_q <= 1'b0;
      end else if (init) begin
         cur_val_q   <= '0;
         cur_valid_q <= 1'b0;
      end else if (sample) begin
         cur_val_q   <= val;
         cur_valid_q <= 1'b1;
      end
   end

   assign cur_val   = cur_val_q;
   assign cur_valid = cur_valid_q;
   assign overflow  = overflow_q;

endmodule
